// File: rtl/mips_ex_mem_stage.sv
// MIPS execute stage fused with the EX/MEM pipeline register and load-use hazard detection.
// Define ALU_OVERFLOW_EN to add the registered ovfMem flag, which suppresses regWrite on signed overflow.
module mips_ex_mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  ctrlEx,
  input  logic [3:0]  aluOpEx,
  input  logic        aluSrcEx,
  input  logic        regDstEx,
  input  logic [31:0] immediateExtendedEx,
  input  logic [4:0]  addressRtEx,
  input  logic [4:0]  addressRdEx,
  input  logic [31:0] dataRsEx,
  input  logic [31:0] dataRtEx,
  input  logic [5:0]  funcEx,
  input  logic [1:0]  forwardingMux0Ex,
  input  logic [1:0]  forwardingMux1Ex,
  input  logic [31:0] regWriteDataWb,
  input  logic [4:0]  addressRsId,
  input  logic [4:0]  addressRtId,
  output logic        hazard,
  output logic [31:0] aluResultEx,
  output logic        aluResultZeroEx,
  output logic [4:0]  regWriteRegisterEx,
  output logic [3:0]  ctrlMem,
  output logic [31:0] aluResultMemInput,
  output logic [31:0] memWriteDataMemInput,
  output logic [4:0]  regWriteRegisterMemInput
`ifdef ALU_OVERFLOW_EN
  ,
  output logic        ovfMem
`endif
);

  localparam logic [3:0] opAdd   = 4'b0000;
  localparam logic [3:0] opSub   = 4'b0001;
  localparam logic [3:0] opRtype = 4'b0010;
  localparam logic [3:0] opAnd   = 4'b0011;
  localparam logic [3:0] opOr    = 4'b0100;
  localparam logic [3:0] opSlt   = 4'b0101;
  localparam logic [3:0] opLui   = 4'b0110;

  localparam logic [5:0] fnAdd  = 6'b100000;
  localparam logic [5:0] fnAddu = 6'b100001;
  localparam logic [5:0] fnSub  = 6'b100010;
  localparam logic [5:0] fnSubu = 6'b100011;
  localparam logic [5:0] fnAnd  = 6'b100100;
  localparam logic [5:0] fnOr   = 6'b100101;
  localparam logic [5:0] fnXor  = 6'b100110;
  localparam logic [5:0] fnNor  = 6'b100111;
  localparam logic [5:0] fnSlt  = 6'b101010;
  localparam logic [5:0] fnSltu = 6'b101011;
  localparam logic [5:0] fnSll  = 6'b000000;
  localparam logic [5:0] fnSrl  = 6'b000010;
  localparam logic [5:0] fnSra  = 6'b000011;

  logic [31:0] opA;
  logic [31:0] fwdRt;
  logic [31:0] opB;
  logic [31:0] rTypeResult;
  logic [4:0]  shamt;
  logic [3:0]  ctrlNext;

  assign shamt = immediateExtendedEx[10:6];

  // Forwarding selects 10 feed back our own EX/MEM result for back-to-back dependencies.
  always_comb begin
    case (forwardingMux0Ex)
      2'b01:   opA = regWriteDataWb;
      2'b10:   opA = aluResultMemInput;
      default: opA = dataRsEx;
    endcase
  end

  always_comb begin
    case (forwardingMux1Ex)
      2'b01:   fwdRt = regWriteDataWb;
      2'b10:   fwdRt = aluResultMemInput;
      default: fwdRt = dataRtEx;
    endcase
  end

  assign opB                = aluSrcEx ? immediateExtendedEx : fwdRt;
  assign regWriteRegisterEx = regDstEx ? addressRdEx : addressRtEx;

  // Shifts take the forwarded rt value and the shamt field, never operand B.
  always_comb begin
    rTypeResult = '0;
    case (funcEx)
      fnAdd, fnAddu: rTypeResult = opA + opB;
      fnSub, fnSubu: rTypeResult = opA - opB;
      fnAnd:         rTypeResult = opA & opB;
      fnOr:          rTypeResult = opA | opB;
      fnXor:         rTypeResult = opA ^ opB;
      fnNor:         rTypeResult = ~(opA | opB);
      fnSlt:         rTypeResult = {31'd0, $signed(opA) < $signed(opB)};
      fnSltu:        rTypeResult = {31'd0, opA < opB};
      fnSll:         rTypeResult = fwdRt << shamt;
      fnSrl:         rTypeResult = fwdRt >> shamt;
      fnSra:         rTypeResult = $signed(fwdRt) >>> shamt;
      default:       rTypeResult = '0;
    endcase
  end

  always_comb begin
    aluResultEx = '0;
    case (aluOpEx)
      opAdd:   aluResultEx = opA + opB;
      opSub:   aluResultEx = opA - opB;
      opRtype: aluResultEx = rTypeResult;
      opAnd:   aluResultEx = opA & opB;
      opOr:    aluResultEx = opA | opB;
      opSlt:   aluResultEx = {31'd0, $signed(opA) < $signed(opB)};
      opLui:   aluResultEx = {opB[15:0], 16'h0000};
      default: aluResultEx = '0;
    endcase
  end

  assign aluResultZeroEx = (aluResultEx == 32'd0);

`ifdef ALU_OVERFLOW_EN
  logic isSignedAdd;
  logic isSignedSub;
  logic overflowEx;

  // Only the trapping forms flag; addu/subu wrap silently.
  assign isSignedAdd = (aluOpEx == opAdd) || ((aluOpEx == opRtype) && (funcEx == fnAdd));
  assign isSignedSub = (aluOpEx == opSub) || ((aluOpEx == opRtype) && (funcEx == fnSub));
  assign overflowEx  = (isSignedAdd && (opA[31] == opB[31]) && (aluResultEx[31] != opA[31])) ||
                       (isSignedSub && (opA[31] != opB[31]) && (aluResultEx[31] != opA[31]));
  assign ctrlNext    = {ctrlEx[3], ctrlEx[2] & ~overflowEx, ctrlEx[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ovfMem <= 1'b0;
    else        ovfMem <= overflowEx;
  end
`else
  assign ctrlNext = ctrlEx;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrlMem                  <= '0;
      aluResultMemInput        <= '0;
      memWriteDataMemInput     <= '0;
      regWriteRegisterMemInput <= '0;
    end else begin
      ctrlMem                  <= ctrlNext;
      aluResultMemInput        <= aluResultEx;
      memWriteDataMemInput     <= fwdRt;
      regWriteRegisterMemInput <= regWriteRegisterEx;
    end
  end

  // A load in EX whose target is read by the instruction in ID must stall it one cycle.
  assign hazard = ctrlEx[0] && (regWriteRegisterEx != 5'd0) &&
                  ((regWriteRegisterEx == addressRsId) || (regWriteRegisterEx == addressRtId));

endmodule

// File: tb/tb_mips_ex_mem_stage.sv
// Testbench for mips_ex_mem_stage: directed steps plus randomized traffic against a behavioural model.
// Build with ALU_OVERFLOW_EN defined to also exercise the overflow flag.
module tb_mips_ex_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  ctrlEx;
  logic [3:0]  aluOpEx;
  logic        aluSrcEx;
  logic        regDstEx;
  logic [31:0] immediateExtendedEx;
  logic [4:0]  addressRtEx;
  logic [4:0]  addressRdEx;
  logic [31:0] dataRsEx;
  logic [31:0] dataRtEx;
  logic [5:0]  funcEx;
  logic [1:0]  forwardingMux0Ex;
  logic [1:0]  forwardingMux1Ex;
  logic [31:0] regWriteDataWb;
  logic [4:0]  addressRsId;
  logic [4:0]  addressRtId;
  logic        hazard;
  logic [31:0] aluResultEx;
  logic        aluResultZeroEx;
  logic [4:0]  regWriteRegisterEx;
  logic [3:0]  ctrlMem;
  logic [31:0] aluResultMemInput;
  logic [31:0] memWriteDataMemInput;
  logic [4:0]  regWriteRegisterMemInput;
  logic        ovfObserved;
`ifdef ALU_OVERFLOW_EN
  logic        ovfMem;
  assign ovfObserved = ovfMem;
`else
  assign ovfObserved = 1'b0;
`endif

  int assertCount = 0;
  int failCount   = 0;

  // Expected EX/MEM register contents
  logic [3:0]  expCtrlMem = '0;
  logic [31:0] expAluMem  = '0;
  logic [31:0] expRtMem   = '0;
  logic [4:0]  expDestMem = '0;
  logic        expOvfMem  = 1'b0;

  logic [31:0] expResult;
  logic [31:0] expRt;
  logic [4:0]  expDest;
  logic        expOvf;

  mips_ex_mem_stage dut (
    .clk(clk),
    .reset(reset),
    .ctrlEx(ctrlEx),
    .aluOpEx(aluOpEx),
    .aluSrcEx(aluSrcEx),
    .regDstEx(regDstEx),
    .immediateExtendedEx(immediateExtendedEx),
    .addressRtEx(addressRtEx),
    .addressRdEx(addressRdEx),
    .dataRsEx(dataRsEx),
    .dataRtEx(dataRtEx),
    .funcEx(funcEx),
    .forwardingMux0Ex(forwardingMux0Ex),
    .forwardingMux1Ex(forwardingMux1Ex),
    .regWriteDataWb(regWriteDataWb),
    .addressRsId(addressRsId),
    .addressRtId(addressRtId),
    .hazard(hazard),
    .aluResultEx(aluResultEx),
    .aluResultZeroEx(aluResultZeroEx),
    .regWriteRegisterEx(regWriteRegisterEx),
    .ctrlMem(ctrlMem),
    .aluResultMemInput(aluResultMemInput),
    .memWriteDataMemInput(memWriteDataMemInput),
    .regWriteRegisterMemInput(regWriteRegisterMemInput)
`ifdef ALU_OVERFLOW_EN
    ,
    .ovfMem(ovfMem)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refFwd(input logic [1:0] sel, input logic [31:0] regVal,
                                         input logic [31:0] wbVal, input logic [31:0] memVal);
    if (sel == 2'd1) return wbVal;
    if (sel == 2'd2) return memVal;
    return regVal;
  endfunction

  function automatic logic [31:0] refAlu(input logic [3:0] op, input logic [5:0] fn,
                                         input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] rtVal, input int sh);
    int sa, sb, srt;
    sa = a; sb = b; srt = rtVal;
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: begin
        case (fn)
          6'h20, 6'h21: return a + b;
          6'h22, 6'h23: return a - b;
          6'h24: return a & b;
          6'h25: return a | b;
          6'h26: return a ^ b;
          6'h27: return ~(a | b);
          6'h2a: return (sa < sb) ? 32'd1 : 32'd0;
          6'h2b: return (a < b) ? 32'd1 : 32'd0;
          6'h00: return rtVal << sh;
          6'h02: return rtVal >> sh;
          6'h03: return srt >>> sh;
          default: return 32'd0;
        endcase
      end
      4'd3: return a & b;
      4'd4: return a | b;
      4'd5: return (sa < sb) ? 32'd1 : 32'd0;
      4'd6: return b * 32'd65536;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic refOvf(input logic [3:0] op, input logic [5:0] fn,
                                  input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, exact;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'd0 || (op == 4'd2 && fn == 6'h20))      exact = sa + sb;
    else if (op == 4'd1 || (op == 4'd2 && fn == 6'h22)) exact = sa - sb;
    else return 1'b0;
    return (exact > 64'sd2147483647) || (exact < -64'sd2147483648);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] ctrl, input logic [3:0] op, input logic [5:0] fn,
                               input logic src, input logic dst, input logic [31:0] imm,
                               input logic [4:0] rt, input logic [4:0] rd,
                               input logic [31:0] rsData, input logic [31:0] rtData,
                               input logic [1:0] fwd0, input logic [1:0] fwd1, input logic [31:0] wb,
                               input logic [4:0] rsId, input logic [4:0] rtId);
    ctrlEx = ctrl; aluOpEx = op; funcEx = fn; aluSrcEx = src; regDstEx = dst;
    immediateExtendedEx = imm; addressRtEx = rt; addressRdEx = rd;
    dataRsEx = rsData; dataRtEx = rtData; forwardingMux0Ex = fwd0; forwardingMux1Ex = fwd1;
    regWriteDataWb = wb; addressRsId = rsId; addressRtId = rtId;
  endtask

  // Combinational outputs checked before the edge; the model predicts the next register state.
  task automatic checkComb();
    logic [31:0] a, b;
    logic expHazard;
    #1;
    a         = refFwd(forwardingMux0Ex, dataRsEx, regWriteDataWb, expAluMem);
    expRt     = refFwd(forwardingMux1Ex, dataRtEx, regWriteDataWb, expAluMem);
    b         = aluSrcEx ? immediateExtendedEx : expRt;
    expResult = refAlu(aluOpEx, funcEx, a, b, expRt, int'(immediateExtendedEx[10:6]));
    expDest   = regDstEx ? addressRdEx : addressRtEx;
    expHazard = ctrlEx[0] && expDest != 0 && (expDest == addressRsId || expDest == addressRtId);
`ifdef ALU_OVERFLOW_EN
    expOvf    = refOvf(aluOpEx, funcEx, a, b);
`else
    expOvf    = 1'b0;
`endif
    checkOutput("aluResultEx", aluResultEx, expResult);
    checkOutput("aluResultZeroEx", 32'(aluResultZeroEx), 32'(expResult == 32'd0));
    checkOutput("regWriteRegisterEx", 32'(regWriteRegisterEx), 32'(expDest));
    checkOutput("hazard", 32'(hazard), 32'(expHazard));
  endtask

  task automatic clockAndCheck();
    @(posedge clk);
    #1;
    if (reset === 1'b0) begin
      expCtrlMem = '0; expAluMem = '0; expRtMem = '0; expDestMem = '0; expOvfMem = 1'b0;
    end else begin
      expCtrlMem = expOvf ? (ctrlEx & 4'b1011) : ctrlEx;
      expAluMem  = expResult;
      expRtMem   = expRt;
      expDestMem = expDest;
      expOvfMem  = expOvf;
    end
    checkOutput("ctrlMem", 32'(ctrlMem), 32'(expCtrlMem));
    checkOutput("aluResultMemInput", aluResultMemInput, expAluMem);
    checkOutput("memWriteDataMemInput", memWriteDataMemInput, expRtMem);
    checkOutput("regWriteRegisterMemInput", 32'(regWriteRegisterMemInput), 32'(expDestMem));
    checkOutput("ovfMem", 32'(ovfObserved), 32'(expOvfMem));
  endtask

  initial begin
    logic [5:0] fnList [14];
    logic [15:0] imm16;
    fnList = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2a, 6'h2b, 6'h00, 6'h02, 6'h03, 6'h3f};

    // Reset held low with busy inputs: registers stay cleared, hazard still live
    reset = 1'b0;
    applyStimulus(4'hF, 4'd2, 6'h20, 1'b0, 1'b1, 32'h0, 5'd5, 5'd9, 32'd7, 32'd5, 2'd0, 2'd0, 32'd0, 5'd9, 5'd0);
    checkComb();
    checkOutput("hazardDuringReset", 32'(hazard), 32'd1);
    clockAndCheck();
    clockAndCheck();
    checkOutput("resetCtrlMem", 32'(ctrlMem), 32'd0);
    checkOutput("resetAluMem", aluResultMemInput, 32'd0);
    checkOutput("resetDestMem", 32'(regWriteRegisterMemInput), 32'd0);

    #2 reset = 1'b1;
    checkComb();
    clockAndCheck();
    checkOutput("postResetCtrlMem", 32'(ctrlMem), 32'hF);

    // R-type ADD then SUB, regDst selecting rd
    applyStimulus(4'b0100, 4'd2, 6'h20, 1'b0, 1'b1, 32'h0, 5'd5, 5'd9, 32'd7, 32'd5, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    checkOutput("rtypeAdd", aluResultEx, 32'd12);
    clockAndCheck();
    checkOutput("rdDestMem", 32'(regWriteRegisterMemInput), 32'd9);

    applyStimulus(4'b0100, 4'd2, 6'h20, 1'b0, 1'b1, 32'h0, 5'd5, 5'd9, 32'd7, 32'd1, 2'd2, 2'd0, 32'd100, 5'd0, 5'd0);
    checkComb();
    checkOutput("fwdMemAdd", aluResultEx, 32'd13);
    clockAndCheck();

    applyStimulus(4'b0100, 4'd2, 6'h20, 1'b0, 1'b1, 32'h0, 5'd5, 5'd9, 32'd7, 32'd1, 2'd1, 2'd0, 32'd100, 5'd0, 5'd0);
    checkComb();
    checkOutput("fwdWbAdd", aluResultEx, 32'd101);
    clockAndCheck();

    applyStimulus(4'b0100, 4'd2, 6'h22, 1'b0, 1'b1, 32'h0, 5'd5, 5'd9, 32'd7, 32'd5, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    checkOutput("rtypeSub", aluResultEx, 32'd2);
    clockAndCheck();

    applyStimulus(4'b0010, 4'd0, 6'h00, 1'b1, 1'b0, 32'd8, 5'd5, 5'd9, 32'd7, 32'd5, 2'd0, 2'd1, 32'd100, 5'd0, 5'd0);
    checkComb();
    clockAndCheck();
    checkOutput("fwdRtStoreData", memWriteDataMemInput, 32'd100);

    // Immediate operand, zero flag and signed compare
    applyStimulus(4'b0100, 4'd1, 6'h00, 1'b1, 1'b0, 32'd3, 5'd6, 5'd0, 32'd3, 32'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    checkOutput("subImmZero", 32'(aluResultZeroEx), 32'd1);
    clockAndCheck();

    applyStimulus(4'b0100, 4'd5, 6'h00, 1'b1, 1'b0, 32'd0, 5'd6, 5'd0, 32'hFFFF_FFFF, 32'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    checkOutput("sltNegative", aluResultEx, 32'd1);
    clockAndCheck();

    // Load-use hazard corner cases
    applyStimulus(4'b0101, 4'd0, 6'h00, 1'b1, 1'b0, 32'd0, 5'd4, 5'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 5'd4, 5'd0);
    checkComb();
    checkOutput("hazardRsMatch", 32'(hazard), 32'd1);
    applyStimulus(4'b0101, 4'd0, 6'h00, 1'b1, 1'b0, 32'd0, 5'd4, 5'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 5'd2, 5'd3);
    checkComb();
    checkOutput("hazardNoMatch", 32'(hazard), 32'd0);
    applyStimulus(4'b0101, 4'd0, 6'h00, 1'b1, 1'b0, 32'd0, 5'd0, 5'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    checkOutput("hazardR0", 32'(hazard), 32'd0);
    applyStimulus(4'b0100, 4'd0, 6'h00, 1'b1, 1'b0, 32'd0, 5'd4, 5'd0, 32'd0, 32'd0, 2'd0, 2'd0, 32'd0, 5'd4, 5'd4);
    checkComb();
    checkOutput("hazardNoLoad", 32'(hazard), 32'd0);
    clockAndCheck();

    // Asynchronous reset between edges clears the registers at once
    applyStimulus(4'b1110, 4'd4, 6'h00, 1'b0, 1'b1, 32'd0, 5'd3, 5'd17, 32'hA5A5_0000, 32'h0000_5A5A, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    clockAndCheck();
    #1 reset = 1'b0;
    #1;
    checkOutput("asyncCtrlMem", 32'(ctrlMem), 32'd0);
    checkOutput("asyncAluMem", aluResultMemInput, 32'd0);
    checkOutput("asyncRtMem", memWriteDataMemInput, 32'd0);
    checkOutput("asyncDestMem", 32'(regWriteRegisterMemInput), 32'd0);
    expCtrlMem = '0; expAluMem = '0; expRtMem = '0; expDestMem = '0; expOvfMem = 1'b0;
    #1 reset = 1'b1;

`ifdef ALU_OVERFLOW_EN
    applyStimulus(4'b0100, 4'd0, 6'h00, 1'b1, 1'b0, 32'd1, 5'd2, 5'd0, 32'h7FFF_FFFF, 32'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    clockAndCheck();
    checkOutput("ovfSet", 32'(ovfMem), 32'd1);
    checkOutput("ovfRegWriteMasked", 32'(ctrlMem[2]), 32'd0);
    checkOutput("ovfWrappedResult", aluResultMemInput, 32'h8000_0000);
    applyStimulus(4'b0100, 4'd2, 6'h21, 1'b1, 1'b0, 32'd1, 5'd2, 5'd0, 32'h7FFF_FFFF, 32'd0, 2'd0, 2'd0, 32'd0, 5'd0, 5'd0);
    checkComb();
    clockAndCheck();
    checkOutput("adduNoOvf", 32'(ovfMem), 32'd0);
`endif

    // Randomized traffic; small operands keep zero/compare/hazard cases frequent
    for (int i = 0; i < 400; i++) begin
      imm16 = 16'($urandom);
      applyStimulus(4'($urandom), 4'($urandom_range(0, 7)), fnList[$urandom_range(0, 13)],
                    1'($urandom), 1'($urandom),
                    ($urandom_range(0, 1) == 1) ? {{16{imm16[15]}}, imm16} : 32'($urandom_range(0, 15)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 15)),
                    ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'($urandom_range(0, 15)),
                    2'($urandom), 2'($urandom),
                    ($urandom_range(0, 3) == 0) ? 32'h7FFF_FFFF : 32'($urandom),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      checkComb();
      clockAndCheck();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mips_ex_mem_stage.md
Name: mips_ex_mem_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, fused with the EX/MEM pipeline register and the load-use hazard detector.
- Takes ID/EX-registered operands and controls, then applies forwarding muxes, ALU operand select, ALU and destination-register select.
- Latches results into EX/MEM each clock.
- Flags load-use hazards against the instruction currently in ID.

Parameters:
- none

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; 0 clears all EX/MEM registers
- ctrlEx  in  4  {memToReg, regWrite, memWrite, memRead} of the EX instruction
- aluOpEx  in  4  ALU operation class
- aluSrcEx  in  1  1 = operand B is the immediate
- regDstEx  in  1  1 = destination is rd, 0 = destination is rt
- immediateExtendedEx  in  32  sign-extended immediate
- addressRtEx  in  5  rt index
- addressRdEx  in  5  rd index
- dataRsEx  in  32  rs register data
- dataRtEx  in  32  rt register data
- funcEx  in  6  R-type funct field
- forwardingMux0Ex  in  2  operand A source select
- forwardingMux1Ex  in  2  rt value source select
- regWriteDataWb  in  32  WB-stage write data
- addressRsId  in  5  rs of the instruction in ID
- addressRtId  in  5  rt of the instruction in ID
- hazard  out  1  combinational load-use stall request
- aluResultEx  out  32  combinational ALU result
- aluResultZeroEx  out  1  combinational, (aluResultEx == 0)
- regWriteRegisterEx  out  5  combinational destination index
- ctrlMem  out  4  registered ctrlEx
- aluResultMemInput  out  32  registered ALU result
- memWriteDataMemInput  out  32  registered forwarded rt value
- regWriteRegisterMemInput  out  5  registered destination index

Behaviour:
Forwarding mux 0 (operand A):
- 00 → dataRsEx
- 01 → regWriteDataWb
- 10 → aluResultMemInput (internal EX/MEM value)
- 11 → dataRsEx

Forwarding mux 1 (fwdRt): same encoding, with dataRtEx as the 00/11 source.

Operand and destination select:
- B = aluSrcEx ? immediateExtendedEx : fwdRt
- regWriteRegisterEx = regDstEx ? addressRdEx : addressRtEx

aluOpEx encoding:
- 0000 ADD
- 0001 SUB
- 0010 R-type, decoded from funct
- 0011 AND
- 0100 OR
- 0101 SLT
- 0110 LUI (B << 16)
- others → 0

R-type funct decode:
- 100000 ADD, 100001 ADD, 100010 SUB, 100011 SUB
- 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
- 101010 SLT (signed), 101011 SLTU
- 000000 SLL, 000010 SRL, 000011 SRA: shift fwdRt by immediateExtendedEx[10:6]
- others → 0

Arithmetic and shift rules:
- Arithmetic is 32-bit modulo; the carry is discarded.
- SLT yields 32'd1 or 32'd0.
- SRA replicates bit 31.

EX/MEM register:
- On every rising clk, load ctrlEx, aluResultEx, fwdRt and regWriteRegisterEx.
- There is no enable and no stall input; a stall is inserted upstream.
- Asynchronous reset assertion forces all registered outputs to 0 immediately, including mid-operation.

Hazard detection:
- hazard = ctrlEx[0] & (regWriteRegisterEx != 0) & ((regWriteRegisterEx == addressRsId) | (regWriteRegisterEx == addressRtId))
- Purely combinational and unaffected by reset.

Optional Feature:
- Macro: ALU_OVERFLOW_EN
- Defined:
  - Adds output ovfMem (1 bit, registered, reset 0).
  - Set when the op is signed ADD (aluOp 0000 or funct 100000) or signed SUB (aluOp 0001 or funct 100010) and two's-complement overflow occurs.
  - When set, the registered regWrite bit (ctrlMem[2]) is forced to 0.
  - funct 100001 and 100011 never flag.
- Undefined: the port is absent and wrap-around is silent.

Test Plan:
- Reset: hold reset=0 with nonzero inputs → ctrlMem=0, aluResultMemInput=0, regWriteRegisterMemInput=0. Release reset; after one clk the registers track the inputs.
- R-type ADD/SUB:
  - aluOp=0010, funct=100000, rs=7, rt=5, fwd=00 → aluResultEx=12.
  - funct=100010 → 2.
  - With regDst=1, rd=9 → regWriteRegisterMemInput=9 after the clk edge.
- Forwarding:
  - fwd0=01 with regWriteDataWb=100, rt=1 → 101.
  - fwd0=10 with prior result 12 → 13.
  - fwd1=01 with memWrite → memWriteDataMemInput=100.
- Immediate, zero flag and SLT:
  - aluSrc=1, aluOp=0001, rs=3, imm=3 → aluResultEx=0, aluResultZeroEx=1.
  - aluOp=0101, rs=-1, imm=0 → 1.
- Load-use hazard, with memRead=1, regDst=0, rt=4:
  - ID rs=4 → hazard=1.
  - ID rs=2, rt=3 → 0.
  - EX dest=0 matching ID rs=0 → 0.
  - memRead=0 → 0.
- Overflow (ALU_OVERFLOW_EN defined): ADD 0x7FFFFFFF + 1 with regWrite=1 → ovfMem=1, ctrlMem[2]=0, aluResultMemInput=0x80000000.
